sr_lsu: RTL and testbench

- Load/store unit directly downstream of the control decoder. It consumes the decoder's data-memory controls (dmWe, dmSign, dmOpByte/Half/Word), the ALU address and the rs2 store data.
- It runs one valid/ready bus transaction per memory instruction and stalls the core until that transaction completes.
- It performs byte-lane steering for stores and alignment plus sign/zero extension for loads, and returns write-back data for the WD_SRC_MEM path.

---
 rtl/sr_lsu_pkg.sv | 35 +++
 rtl/sr_lsu_if.sv | 27 ++
 rtl/sr_lsu_align.sv | 52 +++++
 rtl/sr_lsu.sv | 176 +++++++++++++++++
 tb/tb_sr_lsu.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sr_lsu_pkg.sv
// ============================================================================
// sr_lsu_pkg : shared LSU state encodings, access-size codes, size decoder
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sr_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    DM_BYTE = 2'd0,
    DM_HALF = 2'd1,
    DM_WORD = 2'd2
  } dm_size_e;

  // Word wins over half over byte; no size bit at all means a word access.
  function automatic dm_size_e dm_size_decode(input logic op_byte,
                                              input logic op_half,
                                              input logic op_word);
    dm_size_e size;
    if (op_word)      size = DM_WORD;
    else if (op_half) size = DM_HALF;
    else if (op_byte) size = DM_BYTE;
    else              size = DM_WORD;
    return size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_lsu_if.sv
// ============================================================================
// sr_lsu_if : valid/ready data-memory bus between the LSU and memory
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface sr_lsu_if;
  logic        busValid;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWData;
  logic        busReady;
  logic [31:0] busRData;

  modport master (
    output busValid, busWe, busAddr, busBe, busWData,
    input  busReady, busRData
  );

  modport slave (
    input  busValid, busWe, busAddr, busBe, busWData,
    output busReady, busRData
  );
endinterface

`default_nettype wire

// File: rtl/sr_lsu_align.sv
// ============================================================================
// sr_lsu_align : byte-lane steering, load extraction and misalign detection
// Revision     : 1.0
// ============================================================================
`default_nettype none

module sr_lsu_align
  import sr_lsu_pkg::*;
(
  input  dm_size_e    size,
  input  logic [1:0]  addr,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr, 3'b000} +: 8];
  assign rd_half = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata;
    rdata_out = rdata;
    misalign  = 1'b0;
    case (size)
      DM_BYTE: begin
        be        = 4'b0001 << addr;
        wdata_out = {4{wdata[7:0]}};
        rdata_out = {{24{sign & rd_byte[7]}}, rd_byte};
      end
      DM_HALF: begin
        misalign  = addr[0];
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata[15:0]}};
        rdata_out = {{16{sign & rd_half[15]}}, rd_half};
      end
      default: begin
        misalign  = |addr;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sr_lsu.sv
// ============================================================================
// sr_lsu : load/store unit, one bus transaction per memory op, stalls the core
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_lsu
  import sr_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dmRe,
  input  logic         dmWe,
  input  logic         dmSign,
  input  logic         dmOpByte,
  input  logic         dmOpHalf,
  input  logic         dmOpWord,
  input  logic [31:0]  dmAddr,
  input  logic [31:0]  dmWData,
  output logic [31:0]  dmRData,
  output logic         lsuStall,
  output logic         lsuMisalign,
  output logic         lsuErr,
  sr_lsu_if.master     bus
);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  dm_size_e    size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        sign_q, sign_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        in_idle;
  logic        start;
  dm_size_e    size_live;
  dm_size_e    al_size;
  logic [1:0]  al_addr;
  logic        al_sign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  assign req       = dmRe | dmWe;
  assign in_idle   = (state_q == LSU_IDLE);
  assign size_live = dm_size_decode(dmOpByte, dmOpHalf, dmOpWord);

  // Live core inputs steer the aligner in IDLE; the captured access info in REQ.
  assign al_size = in_idle ? size_live   : size_q;
  assign al_addr = in_idle ? dmAddr[1:0] : off_q;
  assign al_sign = in_idle ? dmSign      : sign_q;

  sr_lsu_align u_align (
    .size      (al_size),
    .addr      (al_addr),
    .sign      (al_sign),
    .wdata     (dmWData),
    .rdata     (bus.busRData),
    .be        (al_be),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata),
    .misalign  (al_misalign)
  );

  assign start = in_idle & req & ~al_misalign;

  // Combinational handshakes are gated with rst_n so reset silences them at once.
  assign lsuMisalign = rst_n & in_idle & req & al_misalign;
  assign lsuStall    = rst_n & (start | (state_q == LSU_REQ));
  assign dmRData     = lsuMisalign ? 32'd0 : rdata_q;
  assign lsuErr      = err_q;

  assign bus.busValid = valid_q;
  assign bus.busWe    = we_q;
  assign bus.busAddr  = addr_q;
  assign bus.busBe    = be_q;
  assign bus.busWData = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    sign_d  = sign_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          state_d = LSU_REQ;
          valid_d = 1'b1;
          cnt_d   = '0;
          we_d    = dmWe;
          addr_d  = {dmAddr[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          size_d  = size_live;
          off_d   = dmAddr[1:0];
          sign_d  = dmSign;
        end
      end
      LSU_REQ: begin
        if (bus.busReady) begin
          if (!we_q) rdata_d = al_rdata;
          valid_d = 1'b0;
          state_d = LSU_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          valid_d = 1'b0;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_DONE: begin
        err_d   = 1'b0;
        state_d = LSU_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= DM_WORD;
      off_q   <= 2'd0;
      sign_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_lsu.sv
// ============================================================================
// tb_sr_lsu : directed plus randomized accesses against a transaction model
// Revision  : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sr_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmRe = 1'b0, dmWe = 1'b0, dmSign = 1'b0;
  logic        dmOpByte = 1'b0, dmOpHalf = 1'b0, dmOpWord = 1'b0;
  logic [31:0] dmAddr = '0, dmWData = '0;
  logic [31:0] dmRData;
  logic        lsuStall, lsuMisalign, lsuErr;

  sr_lsu_if bus ();

  sr_lsu #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmRe        (dmRe),
    .dmWe        (dmWe),
    .dmSign      (dmSign),
    .dmOpByte    (dmOpByte),
    .dmOpHalf    (dmOpHalf),
    .dmOpWord    (dmOpWord),
    .dmAddr      (dmAddr),
    .dmWData     (dmWData),
    .dmRData     (dmRData),
    .lsuStall    (lsuStall),
    .lsuMisalign (lsuMisalign),
    .lsuErr      (lsuErr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One core memory op; memory answers in REQ cycle index wait_n.
  task automatic access(input bit we, input bit re, input bit sign, input bit [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wait_n);
    int nbytes, off, vcnt, scnt, exp_v;
    bit mis, ok;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, v;
    off = int'(addr[1:0]);
    if (sz[2] || sz == 3'b000) nbytes = 4;
    else if (sz[1])            nbytes = 2;
    else                       nbytes = 1;
    mis = (off % nbytes) != 0;
    if (nbytes == 4)      exp_be = 4'hF;
    else if (nbytes == 2) exp_be = 4'(3 << off);
    else                  exp_be = 4'(1 << off);
    if (nbytes == 1)      exp_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
    else if (nbytes == 2) exp_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
    else                  exp_wd = wdata;
    v = rdata >> (8 * off);
    if (nbytes == 1) begin
      v = v & 32'hFF;
      if (sign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = v & 32'hFFFF;
      if (sign && v[15]) v = v | 32'hFFFF_0000;
    end
    ok    = wait_n <= TMO;
    exp_v = ok ? wait_n + 1 : TMO + 1;

    @(negedge clk);
    dmWe = we; dmRe = re; dmSign = sign;
    dmOpByte = sz[0]; dmOpHalf = sz[1]; dmOpWord = sz[2];
    dmAddr = addr; dmWData = wdata;
    bus.busReady = 1'b0; bus.busRData = rdata;
    #1;
    if (mis) begin
      check("misalign_flag", 32'(lsuMisalign), 32'd1);
      check("misalign_stall", 32'(lsuStall), 32'd0);
      check("misalign_rdata", dmRData, 32'd0);
      repeat (2) begin
        @(negedge clk);
        check("misalign_novalid", 32'(bus.busValid), 32'd0);
      end
      dmRe = 1'b0; dmWe = 1'b0;
      return;
    end
    check("idle_misalign", 32'(lsuMisalign), 32'd0);
    check("idle_stall", 32'(lsuStall), 32'd1);
    check("idle_valid", 32'(bus.busValid), 32'd0);
    scnt = 1;
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.busValid) break;
      vcnt++;
      if (lsuStall) scnt++;
      check("req_addr", bus.busAddr, {addr[31:2], 2'b00});
      check("req_be", 32'(bus.busBe), 32'(exp_be));
      check("req_we", 32'(bus.busWe), 32'(we));
      check("req_wdata", bus.busWData, exp_wd);
      bus.busReady = (vcnt - 1 == wait_n);
    end
    bus.busReady = 1'b0;
    if (!ok)     exp_rd = 32'd0;
    else if (!we) exp_rd = v;
    check("valid_cycles", 32'(vcnt), 32'(exp_v));
    check("stall_cycles", 32'(scnt), 32'(exp_v + 1));
    check("done_stall", 32'(lsuStall), 32'd0);
    check("done_err", 32'(lsuErr), 32'(!ok));
    check("done_rdata", dmRData, exp_rd);
    dmRe = 1'b0; dmWe = 1'b0;
    @(negedge clk);
    check("after_err", 32'(lsuErr), 32'd0);
    check("after_rdata", dmRData, exp_rd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.busReady = 1'b0;
    bus.busRData = 32'd0;
    #2;
    check("rst_valid", 32'(bus.busValid), 32'd0);
    check("rst_we", 32'(bus.busWe), 32'd0);
    check("rst_addr", bus.busAddr, 32'd0);
    check("rst_be", 32'(bus.busBe), 32'd0);
    check("rst_wdata", bus.busWData, 32'd0);
    check("rst_rdata", dmRData, 32'd0);
    check("rst_stall", 32'(lsuStall), 32'd0);
    check("rst_err", 32'(lsuErr), 32'd0);
    check("rst_misalign", 32'(lsuMisalign), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    access(1, 0, 0, 3'b001, 32'h0000_1003, 32'h0000_00AB, 32'h1357_9BDF, 0);
    access(0, 1, 1, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
    check("half_signed", exp_rd, 32'hFFFF_8001);
    access(0, 1, 0, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    check("half_unsigned", exp_rd, 32'h0000_8001);
    access(0, 1, 0, 3'b100, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 0);
    access(0, 1, 0, 3'b100, 32'h0000_0100, 32'h0, 32'h1234_5678, 50);
    access(0, 1, 0, 3'b100, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3);

    // Reset pulled in the middle of a wait-stated load.
    @(negedge clk);
    dmRe = 1'b1; dmOpWord = 1'b1; dmOpHalf = 1'b0; dmOpByte = 1'b0;
    dmAddr = 32'h40; bus.busReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rreq_valid", 32'(bus.busValid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rreq_valid_drop", 32'(bus.busValid), 32'd0);
    check("rreq_stall_drop", 32'(lsuStall), 32'd0);
    dmRe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 32'd0;
    @(negedge clk);
    check("rrel_valid", 32'(bus.busValid), 32'd0);
    check("rrel_rdata", dmRData, 32'd0);
    access(0, 1, 0, 3'b001, 32'h0000_0005, 32'h0, 32'h1122_8344, 1);
    check("byte_lane1", exp_rd, 32'h0000_0083);

    for (int i = 0; i < 150; i++) begin
      bit rw, rr;
      rw = 1'($urandom % 2);
      rr = 1'($urandom % 2);
      if (!rw && !rr) rr = 1'b1;
      access(rw, rr, 1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
